hera_alu_seq: RTL and testbench
===============================

// Module: hera_alu_seq
// PURPOSE
//  Parametrised multi-cycle HERA execute unit, successor to the single-cycle ALU. Executes
//  arith/logic/shift ops in 1 cycle and signed multiply iteratively (WIDTH cycles), with a
//  valid/ready handshake on both sides. Owns the flag register {CB,C,V,Z,S}. Sits between
//  decoder issue and RF writeback; result_hi feeds the temp register.
// PARAMETERS
//  WIDTH     16  datapath width; >=8, even
//  CNT_W      5  iteration counter width; 2**CNT_W > WIDTH
// PORTS
//  clk         in   1      clock
//  rst         in   1      synchronous reset, active-low
//  in_valid    in   1      operation offered
//  in_ready    out  1      unit idle, can accept
//  op          in   4      0 ADD,1 SUB,2 AND,3 OR,4 XOR,5 MUL,6 LSL,7 LSR,8 ASR,9 INC,10 DEC,11 DIV
//  opa, opb    in   WIDTH  operands (INC/DEC use opb as immediate)
//  out_valid   out  1      result available
//  out_ready   in   1      consumer takes result
//  result      out  WIDTH  low result
//  result_hi   out  WIDTH  MUL high half / DIV remainder; 0 otherwise
//  flag_wr     in   1      load flags from flag_in (restore/SETF/CLRF path)
//  flag_in     in   5      {CB,C,V,Z,S}
//  flags       out  5      current {CB,C,V,Z,S}
// BEHAVIOUR
//  - Reset (rst=0 at posedge): state IDLE, in_ready=1, out_valid=0, result=result_hi=0,
//    flags=0, counter=0. Reset mid-multiply aborts; no result is produced.
//  - States: IDLE -(accept, 1-cycle op)-> DONE; IDLE -(accept MUL/DIV)-> ITER;
//    ITER -(count==WIDTH-1)-> DONE; DONE -(out_ready)-> IDLE.
//  - in_ready = (state==IDLE). Accept = in_valid & in_ready; operands are registered then.
//  - out_valid=1 only in DONE; result/result_hi held stable until out_ready. Latency: 1-cycle
//    ops out_valid 1 cycle after accept; MUL WIDTH+1 cycles. Throughput: new accept earliest
//    the cycle after the out_ready handshake.
//  - cin = C & ~CB. ADD {c,r}=a+b+cin. SUB r=a+~b+(CB?1:C); C=carry out (1 = no borrow).
//    INC r=a+b+1; DEC r=a-(b+1). V = signed overflow for ADD/SUB/INC/DEC.
//  - AND/OR/XOR: C,V unchanged. LSL r={a[W-2:0],cin}, C=a[W-1]; LSR r={cin,a[W-1:1]},
//    C=a[0]; ASR r={a[W-1],a[W-1:1]}, C=a[0]; V unchanged for shifts.
//  - MUL: signed WxW -> 2W product via radix-2 shift-add on magnitudes, sign fixed on final
//    step. {result_hi,result}=product. S=product[2W-1], Z=(product==0),
//    V=(result_hi != {WIDTH{result[W-1]}}), C unchanged.
//  - Other ops: S=result[W-1], Z=(result==0). CB only changes via flag_wr.
//  - Flags update on the IDLE/ITER->DONE transition. flag_wr honoured only in IDLE and when
//    no accept occurs that cycle; otherwise ignored. Flags used by an op are the values at
//    accept.
//  - Undefined op codes (12-15): result=0, result_hi=0, flags unchanged, latency 1.
// CONFIGURATION
//  HERA_ALU_DIV_EN defined: op 11 = unsigned restoring divide, WIDTH iterations (same latency
//   as MUL); result=a/b, result_hi=a%b, Z=(result==0), S=0, V=0, C unchanged. b==0: no
//   iteration, DONE next cycle, result={WIDTH{1}}, result_hi=a, V=1.
//  Not defined: op 11 treated as undefined op (result 0, flags unchanged, latency 1); no
//   divider hardware.
// TESTING (WIDTH=16)
//  ADD 0x7FFF+0x0001, C=0,CB=0 -> result 0x8000, S=1 V=1 C=0 Z=0, out_valid 1 cycle after accept
//  SUB 0x0005-0x0005 with CB=1 -> result 0x0000, Z=1 C=1 V=0 S=0
//  MUL 0xFFFE*0x0003 -> result 0xFFFA, result_hi 0xFFFF, S=1 V=0 Z=0, out_valid 17 cycles after accept
//  MUL 0x4000*0x0004 -> result 0x0000, result_hi 0x0001, V=1 Z=0 S=0
//  out_ready low 5 cycles after ADD -> result stable, in_ready=0, flags stable; IDLE after handshake
//  rst low at MUL iteration 8 -> next cycle out_valid=0, in_ready=1, flags=0; no stray out_valid
//  (DIV_EN) DIV 0x0064/0x0007 -> result 0x000E, result_hi 0x0002; DIV by 0 -> 0xFFFF, V=1

Source files
------------

// File: rtl/hera_alu_seq.sv
`default_nettype none
// ============================================================================
// Module      : hera_alu_seq
// Description : Multi-cycle HERA execute unit. Arithmetic, logic and shift
//               ops complete in one cycle. Signed multiply runs an
//               iterative radix-2 shift-add for WIDTH cycles. Valid/ready
//               handshakes are used on both the issue and result sides. The
//               unit owns the {CB,C,V,Z,S} flag register.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Optional feature macro: HERA_ALU_DIV_EN
//   defined     -> op 11 is an unsigned restoring divide (WIDTH iterations)
//   not defined -> op 11 is an undefined op; no divider hardware is built
// ----------------------------------------------------------------------------
// Ports
//   clk        in   1      clock
//   rst        in   1      synchronous reset, active-low
//   in_valid   in   1      operation offered
//   in_ready   out  1      unit idle, can accept
//   op         in   4      0 ADD 1 SUB 2 AND 3 OR 4 XOR 5 MUL 6 LSL 7 LSR
//                          8 ASR 9 INC 10 DEC 11 DIV
//   opa, opb   in   WIDTH  operands (INC/DEC use opb as the immediate)
//   out_valid  out  1      result available
//   out_ready  in   1      consumer takes result
//   result     out  WIDTH  low result
//   result_hi  out  WIDTH  MUL high half / DIV remainder, otherwise 0
//   flag_wr    in   1      load flags from flag_in
//   flag_in    in   5      {CB,C,V,Z,S}
//   flags      out  5      current {CB,C,V,Z,S}
// ============================================================================
module hera_alu_seq #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] opa,
    input  logic [WIDTH-1:0] opb,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    input  logic             flag_wr,
    input  logic [4:0]       flag_in,
    output logic [4:0]       flags
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ITER = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd3;
    localparam logic [3:0] OP_XOR = 4'd4;
    localparam logic [3:0] OP_MUL = 4'd5;
    localparam logic [3:0] OP_LSL = 4'd6;
    localparam logic [3:0] OP_LSR = 4'd7;
    localparam logic [3:0] OP_ASR = 4'd8;
    localparam logic [3:0] OP_INC = 4'd9;
    localparam logic [3:0] OP_DEC = 4'd10;
`ifdef HERA_ALU_DIV_EN
    localparam logic [3:0] OP_DIV = 4'd11;
`endif

    localparam logic [CNT_W-1:0]   c_last  = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0]   c_cnt1  = CNT_W'(1);
    localparam logic [WIDTH-1:0]   c_one   = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [2*WIDTH-1:0] c_one2  = {{(2*WIDTH-1){1'b0}}, 1'b1};

    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]   r_result;
    logic [WIDTH-1:0]   r_result_hi;
    logic [4:0]         r_flags;
    // Iteration register: MUL holds {partial_hi, multiplier}, DIV holds
    // {remainder, quotient}. r_m is the multiplicand magnitude / divisor.
    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH-1:0]   r_m;
    logic               r_sign;
`ifdef HERA_ALU_DIV_EN
    logic               r_is_div;
`endif

    logic w_accept;
    logic w_last;
    assign w_accept = in_valid && (r_state == S_IDLE);
    assign w_last   = (r_cnt == c_last);

    // ------------------------------------------------------------------
    // Single-cycle ALU, evaluated on the live operands at accept
    // ------------------------------------------------------------------
    logic             w_cin;
    logic [WIDTH-1:0] w_addend;
    logic             w_cy;
    logic             w_arith;
    logic             w_upd;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH-1:0] w_alu_res;
    logic             w_c;
    logic             w_v;
    logic [4:0]       w_alu_flags;

    assign w_cin = r_flags[3] & ~r_flags[4];

    always_comb begin
        w_addend  = opb;
        w_cy      = w_cin;
        w_arith   = 1'b0;
        w_upd     = 1'b1;
        w_alu_res = '0;
        w_c       = r_flags[3];
        w_v       = r_flags[2];
        case (op)
            OP_ADD: begin w_addend = opb;  w_cy = w_cin; w_arith = 1'b1; end
            OP_SUB: begin w_addend = ~opb; w_cy = r_flags[4] ? 1'b1 : r_flags[3]; w_arith = 1'b1; end
            OP_INC: begin w_addend = opb;  w_cy = 1'b1;  w_arith = 1'b1; end
            // a - (b + 1) == a + ~b
            OP_DEC: begin w_addend = ~opb; w_cy = 1'b0;  w_arith = 1'b1; end
            OP_AND: w_alu_res = opa & opb;
            OP_OR:  w_alu_res = opa | opb;
            OP_XOR: w_alu_res = opa ^ opb;
            OP_LSL: begin w_alu_res = {opa[WIDTH-2:0], w_cin};      w_c = opa[WIDTH-1]; end
            OP_LSR: begin w_alu_res = {w_cin, opa[WIDTH-1:1]};      w_c = opa[0];       end
            OP_ASR: begin w_alu_res = {opa[WIDTH-1], opa[WIDTH-1:1]}; w_c = opa[0];     end
            default: w_upd = 1'b0;
        endcase
        w_sum = {1'b0, opa} + {1'b0, w_addend} + {{WIDTH{1'b0}}, w_cy};
        if (w_arith) begin
            w_alu_res = w_sum[WIDTH-1:0];
            w_c       = w_sum[WIDTH];
            w_v       = (opa[WIDTH-1] == w_addend[WIDTH-1]) && (w_sum[WIDTH-1] != opa[WIDTH-1]);
        end
        w_alu_flags = w_upd ? {r_flags[4], w_c, w_v, (w_alu_res == '0), w_alu_res[WIDTH-1]}
                            : r_flags;
    end

    // ------------------------------------------------------------------
    // Multiplier step: add multiplicand into the high half when the
    // current multiplier LSB is set, then shift the whole register right.
    // ------------------------------------------------------------------
    logic [WIDTH-1:0]   w_abs_a;
    logic [WIDTH-1:0]   w_abs_b;
    logic [WIDTH:0]     w_mul_sum;
    logic [2*WIDTH-1:0] w_mul_next;
    logic [2*WIDTH-1:0] w_prod;
    logic [4:0]         w_mul_flags;

    assign w_abs_a    = opa[WIDTH-1] ? (~opa + c_one) : opa;
    assign w_abs_b    = opb[WIDTH-1] ? (~opb + c_one) : opb;
    assign w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, r_m};
    assign w_mul_next = r_acc[0] ? {w_mul_sum, r_acc[WIDTH-1:1]}
                                 : {1'b0, r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1:1]};
    // Sign applied to the magnitude product on the final step only
    assign w_prod     = r_sign ? (~w_mul_next + c_one2) : w_mul_next;
    assign w_mul_flags = {r_flags[4], r_flags[3],
                          (w_prod[2*WIDTH-1:WIDTH] != {WIDTH{w_prod[WIDTH-1]}}),
                          (w_prod == '0), w_prod[2*WIDTH-1]};

`ifdef HERA_ALU_DIV_EN
    // Restoring divide step: shift next dividend bit into the remainder,
    // subtract the divisor when it fits, and shift the quotient bit in.
    logic [WIDTH:0]     w_div_sh;
    logic [WIDTH:0]     w_div_sub;
    logic               w_div_ge;
    logic [WIDTH-1:0]   w_div_rem;
    logic [2*WIDTH-1:0] w_div_next;
    logic [4:0]         w_div_flags;

    assign w_div_sh    = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
    assign w_div_sub   = w_div_sh - {1'b0, r_m};
    assign w_div_ge    = (w_div_sh >= {1'b0, r_m});
    assign w_div_rem   = w_div_ge ? w_div_sub[WIDTH-1:0] : w_div_sh[WIDTH-1:0];
    assign w_div_next  = {w_div_rem, r_acc[WIDTH-2:0], w_div_ge};
    assign w_div_flags = {r_flags[4], r_flags[3], 1'b0, (w_div_next[WIDTH-1:0] == '0), 1'b0};
`endif

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) r_state <= S_IDLE;
        else      r_state <= w_state_nxt;
    end

    // FSM: next state
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (op == OP_MUL)
                        w_state_nxt = S_ITER;
`ifdef HERA_ALU_DIV_EN
                    else if (op == OP_DIV && opb != '0)
                        w_state_nxt = S_ITER;
`endif
                    else
                        w_state_nxt = S_DONE;
                end
            end
            S_ITER:  if (w_last)    w_state_nxt = S_DONE;
            S_DONE:  if (out_ready) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        in_ready  = (r_state == S_IDLE);
        out_valid = (r_state == S_DONE);
    end

    assign result    = r_result;
    assign result_hi = r_result_hi;
    assign flags     = r_flags;

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_cnt       <= '0;
            r_result    <= '0;
            r_result_hi <= '0;
            r_flags     <= '0;
            r_acc       <= '0;
            r_m         <= '0;
            r_sign      <= 1'b0;
`ifdef HERA_ALU_DIV_EN
            r_is_div    <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_cnt <= '0;
`ifdef HERA_ALU_DIV_EN
                        r_is_div <= (op == OP_DIV);
`endif
                        if (op == OP_MUL) begin
                            r_m    <= w_abs_a;
                            r_acc  <= {{WIDTH{1'b0}}, w_abs_b};
                            r_sign <= opa[WIDTH-1] ^ opb[WIDTH-1];
                        end
`ifdef HERA_ALU_DIV_EN
                        else if (op == OP_DIV) begin
                            r_m   <= opb;
                            r_acc <= {{WIDTH{1'b0}}, opa};
                            if (opb == '0) begin
                                r_result    <= {WIDTH{1'b1}};
                                r_result_hi <= opa;
                                r_flags     <= {r_flags[4], r_flags[3], 1'b1, 1'b0, 1'b0};
                            end
                        end
`endif
                        else begin
                            r_result    <= w_alu_res;
                            r_result_hi <= '0;
                            r_flags     <= w_alu_flags;
                        end
                    end else if (flag_wr) begin
                        r_flags <= flag_in;
                    end
                end
                S_ITER: begin
                    r_cnt <= r_cnt + c_cnt1;
`ifdef HERA_ALU_DIV_EN
                    if (r_is_div) begin
                        r_acc <= w_div_next;
                        if (w_last) begin
                            r_result    <= w_div_next[WIDTH-1:0];
                            r_result_hi <= w_div_next[2*WIDTH-1:WIDTH];
                            r_flags     <= w_div_flags;
                        end
                    end else
`endif
                    begin
                        r_acc <= w_mul_next;
                        if (w_last) begin
                            r_result    <= w_prod[WIDTH-1:0];
                            r_result_hi <= w_prod[2*WIDTH-1:WIDTH];
                            r_flags     <= w_mul_flags;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_hera_alu_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_hera_alu_seq
// Description : Directed self-checking bench for hera_alu_seq (WIDTH=16).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hera_alu_seq;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         out_ready;
    logic         flag_wr;
    logic [3:0]   op;
    logic [W-1:0] opa;
    logic [W-1:0] opb;
    logic [4:0]   flag_in;
    wire          in_ready;
    wire          out_valid;
    wire  [W-1:0] result;
    wire  [W-1:0] result_hi;
    wire  [4:0]   flags;

    int tests = 0;
    int fails = 0;

    hera_alu_seq #(.WIDTH(W), .CNT_W(5)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .opa(opa), .opb(opb), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .result_hi(result_hi), .flag_wr(flag_wr),
        .flag_in(flag_in), .flags(flags)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_flags(input logic [4:0] v);
        flag_wr = 1'b1; flag_in = v; tick; flag_wr = 1'b0;
    endtask

    task automatic issue(input logic [3:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        int n = 0;
        while (in_ready !== 1'b1 && n < 50) begin tick; n++; end
        tests++;
        if (in_ready !== 1'b1) begin fails++; $display("FAIL issue_ready: in_ready=%b required 1", in_ready); end
        op = o; opa = a; opb = b; in_valid = 1'b1;
        tick;
        in_valid = 1'b0;
    endtask

    task automatic drain;
        out_ready = 1'b1; tick; out_ready = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b0; tick; tick; rst = 1'b1;
        tests++; if (in_ready !== 1'b1)  begin fails++; $display("FAIL reset_in_ready: got %b required 1", in_ready); end
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid: got %b required 0", out_valid); end
        tests++; if (result !== 16'h0)   begin fails++; $display("FAIL reset_result: got %h required 0000", result); end
        tests++; if (result_hi !== 16'h0) begin fails++; $display("FAIL reset_result_hi: got %h required 0000", result_hi); end
        tests++; if (flags !== 5'b0)     begin fails++; $display("FAIL reset_flags: got %b required 00000", flags); end
    endtask

    task automatic test_add;
        set_flags(5'b00000);
        issue(4'd0, 16'h7FFF, 16'h0001);
        tests++; if (out_valid !== 1'b1)  begin fails++; $display("FAIL add_latency: out_valid=%b required 1", out_valid); end
        tests++; if (result !== 16'h8000) begin fails++; $display("FAIL add_result: got %h required 8000", result); end
        tests++; if (flags !== 5'b00101)  begin fails++; $display("FAIL add_flags: got %b required 00101", flags); end
        drain;
    endtask

    task automatic test_sub;
        set_flags(5'b10000);
        tests++; if (flags !== 5'b10000) begin fails++; $display("FAIL flag_wr_load: got %b required 10000", flags); end
        issue(4'd1, 16'h0005, 16'h0005);
        tests++; if (result !== 16'h0000) begin fails++; $display("FAIL sub_result: got %h required 0000", result); end
        tests++; if (flags !== 5'b11010)  begin fails++; $display("FAIL sub_flags: got %b required 11010", flags); end
        drain;
    endtask

    task automatic test_flag_wr;
        set_flags(5'b00000);
        // flag_wr coincident with an accept is ignored
        flag_wr = 1'b1; flag_in = 5'b11111;
        issue(4'd2, 16'h0000, 16'h0000);
        flag_wr = 1'b0;
        tests++; if (flags !== 5'b00010) begin fails++; $display("FAIL flag_wr_on_accept: got %b required 00010", flags); end
        drain;
    endtask

    task automatic test_alu_table;
        logic [3:0]   t_op  [11] = '{4'd6, 4'd7, 4'd8, 4'd2, 4'd3, 4'd4, 4'd9, 4'd10, 4'd0, 4'd12, 4'd0};
        logic [W-1:0] t_a   [11] = '{16'h8001, 16'h0002, 16'h8004, 16'h0F0F, 16'h0F0F, 16'hFFFF,
                                     16'h7FFF, 16'h0000, 16'hFFFF, 16'h0005, 16'h0001};
        logic [W-1:0] t_b   [11] = '{16'h0000, 16'h0000, 16'h0000, 16'hF0F0, 16'hF0F0, 16'h00FF,
                                     16'h0000, 16'h0000, 16'h0001, 16'h0005, 16'h0001};
        logic [W-1:0] t_res [11] = '{16'h0003, 16'h8001, 16'hC002, 16'h0000, 16'hFFFF, 16'hFF00,
                                     16'h8000, 16'hFFFF, 16'h0000, 16'h0000, 16'h0003};
        logic [4:0]   t_flg [11] = '{5'b01000, 5'b00001, 5'b00001, 5'b00010, 5'b00001, 5'b00001,
                                     5'b00101, 5'b00001, 5'b01010, 5'b01010, 5'b00000};
        set_flags(5'b01000);
        for (int i = 0; i < 11; i++) begin
            issue(t_op[i], t_a[i], t_b[i]);
            tests++; if (out_valid !== 1'b1)  begin fails++; $display("FAIL alu_valid[%0d]: got %b required 1", i, out_valid); end
            tests++; if (result !== t_res[i]) begin fails++; $display("FAIL alu_result[%0d]: got %h required %h", i, result, t_res[i]); end
            tests++; if (result_hi !== 16'h0) begin fails++; $display("FAIL alu_result_hi[%0d]: got %h required 0000", i, result_hi); end
            tests++; if (flags !== t_flg[i])  begin fails++; $display("FAIL alu_flags[%0d]: got %b required %b", i, flags, t_flg[i]); end
            drain;
            tests++; if (in_ready !== 1'b1)   begin fails++; $display("FAIL alu_idle[%0d]: in_ready=%b required 1", i, in_ready); end
        end
    endtask

    task automatic test_back_to_back;
        set_flags(5'b00000);
        issue(4'd0, 16'h7FFF, 16'h0001);
        // Offer a second op and a flag write while the result is held
        in_valid = 1'b1; op = 4'd2; opa = 16'h0; opb = 16'h0;
        flag_wr = 1'b1; flag_in = 5'b11111;
        for (int i = 0; i < 5; i++) begin
            tests++; if (out_valid !== 1'b1)  begin fails++; $display("FAIL hold_valid[%0d]: got %b required 1", i, out_valid); end
            tests++; if (result !== 16'h8000) begin fails++; $display("FAIL hold_result[%0d]: got %h required 8000", i, result); end
            tests++; if (in_ready !== 1'b0)   begin fails++; $display("FAIL hold_in_ready[%0d]: got %b required 0", i, in_ready); end
            tests++; if (flags !== 5'b00101)  begin fails++; $display("FAIL hold_flags[%0d]: got %b required 00101", i, flags); end
            tick;
        end
        in_valid = 1'b0; flag_wr = 1'b0;
        drain;
        tests++; if (in_ready !== 1'b1)  begin fails++; $display("FAIL hold_release_ready: got %b required 1", in_ready); end
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL hold_release_valid: got %b required 0", out_valid); end
        tests++; if (flags !== 5'b00101) begin fails++; $display("FAIL hold_release_flags: got %b required 00101", flags); end
    endtask

    task automatic test_mul;
        logic [W-1:0] m_a  [2] = '{16'hFFFE, 16'h4000};
        logic [W-1:0] m_b  [2] = '{16'h0003, 16'h0004};
        logic [W-1:0] m_lo [2] = '{16'hFFFA, 16'h0000};
        logic [W-1:0] m_hi [2] = '{16'hFFFF, 16'h0001};
        logic [4:0]   m_fl [2] = '{5'b01001, 5'b01100};
        int n;
        set_flags(5'b01000);
        for (int i = 0; i < 2; i++) begin
            issue(4'd5, m_a[i], m_b[i]);
            n = 1;
            while (out_valid !== 1'b1 && n < 40) begin tick; n++; end
            tests++; if (n != 17)               begin fails++; $display("FAIL mul_latency[%0d]: got %0d required 17", i, n); end
            tests++; if (result !== m_lo[i])    begin fails++; $display("FAIL mul_result[%0d]: got %h required %h", i, result, m_lo[i]); end
            tests++; if (result_hi !== m_hi[i]) begin fails++; $display("FAIL mul_result_hi[%0d]: got %h required %h", i, result_hi, m_hi[i]); end
            tests++; if (flags !== m_fl[i])     begin fails++; $display("FAIL mul_flags[%0d]: got %b required %b", i, flags, m_fl[i]); end
            drain;
        end
    endtask

    task automatic test_reset_mid_mul;
        logic seen = 1'b0;
        set_flags(5'b01000);
        issue(4'd5, 16'h0003, 16'h0005);
        for (int i = 0; i < 8; i++) tick;
        rst = 1'b0; tick; rst = 1'b1;
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL rst_mul_valid: got %b required 0", out_valid); end
        tests++; if (in_ready !== 1'b1)  begin fails++; $display("FAIL rst_mul_ready: got %b required 1", in_ready); end
        tests++; if (flags !== 5'b0)     begin fails++; $display("FAIL rst_mul_flags: got %b required 00000", flags); end
        for (int i = 0; i < 25; i++) begin
            if (out_valid === 1'b1) seen = 1'b1;
            tick;
        end
        tests++; if (seen !== 1'b0) begin fails++; $display("FAIL rst_mul_stray: stray out_valid=%b required 0", seen); end
    endtask

`ifdef HERA_ALU_DIV_EN
    task automatic test_div;
        int n;
        set_flags(5'b01000);
        issue(4'd11, 16'h0064, 16'h0007);
        n = 1;
        while (out_valid !== 1'b1 && n < 40) begin tick; n++; end
        tests++; if (n != 17)               begin fails++; $display("FAIL div_latency: got %0d required 17", n); end
        tests++; if (result !== 16'h000E)   begin fails++; $display("FAIL div_result: got %h required 000e", result); end
        tests++; if (result_hi !== 16'h0002) begin fails++; $display("FAIL div_rem: got %h required 0002", result_hi); end
        tests++; if (flags !== 5'b01000)    begin fails++; $display("FAIL div_flags: got %b required 01000", flags); end
        drain;
        issue(4'd11, 16'h1234, 16'h0000);
        tests++; if (out_valid !== 1'b1)    begin fails++; $display("FAIL div0_latency: out_valid=%b required 1", out_valid); end
        tests++; if (result !== 16'hFFFF)   begin fails++; $display("FAIL div0_result: got %h required ffff", result); end
        tests++; if (result_hi !== 16'h1234) begin fails++; $display("FAIL div0_rem: got %h required 1234", result_hi); end
        tests++; if (flags !== 5'b01100)    begin fails++; $display("FAIL div0_flags: got %b required 01100", flags); end
        drain;
    endtask
`else
    task automatic test_div;
        set_flags(5'b01101);
        issue(4'd11, 16'h0064, 16'h0007);
        tests++; if (out_valid !== 1'b1)   begin fails++; $display("FAIL op11_latency: out_valid=%b required 1", out_valid); end
        tests++; if (result !== 16'h0000)  begin fails++; $display("FAIL op11_result: got %h required 0000", result); end
        tests++; if (result_hi !== 16'h0)  begin fails++; $display("FAIL op11_result_hi: got %h required 0000", result_hi); end
        tests++; if (flags !== 5'b01101)   begin fails++; $display("FAIL op11_flags: got %b required 01101", flags); end
        drain;
    endtask
`endif

    initial begin
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0; flag_wr = 1'b0;
        op = 4'd0; opa = '0; opb = '0; flag_in = 5'b0;
        test_reset;
        test_add;
        test_sub;
        test_flag_wr;
        test_alu_table;
        test_back_to_back;
        test_mul;
        test_reset_mid_mul;
        test_div;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
